wt_time_keeper: RTL and testbench

//   12-hour watch time base with AM/PM and push-button time setting. Holds
//   hh:mm:ss counters and advances them from a prescaled CLK tick.

---
 rtl/wt_time_keeper.sv | 161 ++++++++++++++++
 tb/tb_wt_time_keeper.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_time_keeper.sv
// wt_time_keeper: 12-hour BCD watch time base with AM/PM flag,
// prescaled one-second tick and two-button time setting.
module wt_time_keeper #(
  parameter int TICK_DIV = 1000,
  parameter int PRESC_W  = 10
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic [7:0] DEC_H10,
  output logic [7:0] DEC_H1,
  output logic [7:0] DEC_M10,
  output logic [7:0] DEC_M1,
  output logic [7:0] DEC_S10,
  output logic [7:0] DEC_S1,
  output logic [7:0] AP_DATA,
  output logic       SEC_TICK,
  output logic [1:0] SET_MODE
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } mode_t;

  localparam logic [PRESC_W-1:0] PRESC_LAST =
    PRESC_W'(TICK_DIV - 1);

  mode_t              mode_q, mode_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               h10_q, h10_d;
  logic [3:0]         h1_q, h1_d;
  logic [2:0]         m10_q, m10_d;
  logic [3:0]         m1_q, m1_d;
  logic [2:0]         s10_q, s10_d;
  logic [3:0]         s1_q, s1_d;
  logic               pm_q, pm_d;
  logic               tick_q, tick;
  logic               mode_hq, up_hq;
  logic               mode_e, up_e;
  logic               sec_wrap, min_wrap;
  logic               inc_min, inc_hr;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      mode_q  <= RUN;
      presc_q <= '0;
      h10_q   <= 1'b1;
      h1_q    <= 4'd2;
      m10_q   <= '0;
      m1_q    <= '0;
      s10_q   <= '0;
      s1_q    <= '0;
      pm_q    <= 1'b0;
      tick_q  <= 1'b0;
      mode_hq <= 1'b0;
      up_hq   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      h10_q   <= h10_d;
      h1_q    <= h1_d;
      m10_q   <= m10_d;
      m1_q    <= m1_d;
      s10_q   <= s10_d;
      s1_q    <= s1_d;
      pm_q    <= pm_d;
      tick_q  <= tick;
      mode_hq <= BTN_MODE;
      up_hq   <= BTN_UP;
    end
  end

  always_comb begin
    mode_e   = BTN_MODE & ~mode_hq;
    // a simultaneous mode press swallows the up press
    up_e     = BTN_UP & ~up_hq & ~mode_e;
    tick     = (mode_q == RUN) && (presc_q == PRESC_LAST);
    sec_wrap = (s10_q == 3'd5) && (s1_q == 4'd9);
    min_wrap = (m10_q == 3'd5) && (m1_q == 4'd9);
    inc_min  = (tick && sec_wrap)
             || ((mode_q == SET_M) && up_e);
    inc_hr   = (tick && sec_wrap && min_wrap)
             || ((mode_q == SET_H) && up_e);

    mode_d  = mode_q;
    presc_d = '0;
    h10_d   = h10_q;
    h1_d    = h1_q;
    m10_d   = m10_q;
    m1_d    = m1_q;
    s10_d   = s10_q;
    s1_d    = s1_q;
    pm_d    = pm_q;

    if ((mode_q == RUN) && !tick)
      presc_d = presc_q + PRESC_W'(1);

    if (tick) begin
      if (s1_q == 4'd9) begin
        s1_d  = '0;
        s10_d = sec_wrap ? 3'd0 : s10_q + 3'd1;
      end else begin
        s1_d = s1_q + 4'd1;
      end
    end

    if (inc_min) begin
      if (m1_q == 4'd9) begin
        m1_d  = '0;
        m10_d = min_wrap ? 3'd0 : m10_q + 3'd1;
      end else begin
        m1_d = m1_q + 4'd1;
      end
    end

    if (inc_hr) begin
      unique case (1'b1)
        h10_q && (h1_q == 4'd2): begin
          h10_d = 1'b0;
          h1_d  = 4'd1;
        end
        h10_q && (h1_q == 4'd1): begin
          h1_d = 4'd2;
          pm_d = ~pm_q;
        end
        !h10_q && (h1_q == 4'd9): begin
          h10_d = 1'b1;
          h1_d  = '0;
        end
        default: h1_d = h1_q + 4'd1;
      endcase
    end

    if (mode_e) begin
      unique case (mode_q)
        RUN:     mode_d = SET_H;
        SET_H:   mode_d = SET_M;
        SET_M: begin
          mode_d = RUN;
          s10_d  = '0;
          s1_d   = '0;
        end
        default: mode_d = RUN;
      endcase
    end
  end

  assign DEC_H10  = 8'h30 + {7'd0, h10_q};
  assign DEC_H1   = 8'h30 + {4'd0, h1_q};
  assign DEC_M10  = 8'h30 + {5'd0, m10_q};
  assign DEC_M1   = 8'h30 + {4'd0, m1_q};
  assign DEC_S10  = 8'h30 + {5'd0, s10_q};
  assign DEC_S1   = 8'h30 + {4'd0, s1_q};
  assign AP_DATA  = pm_q ? 8'h50 : 8'h41;
  assign SEC_TICK = tick_q;
  assign SET_MODE = mode_q;

endmodule

// File: tb/tb_wt_time_keeper.sv
// tb_wt_time_keeper: scenario tasks plus randomized buttons,
// checked against a seconds-of-day reference model.
module tb_wt_time_keeper;

  localparam int TD = 4;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       BTN_MODE = 1'b0;
  logic       BTN_UP = 1'b0;
  logic [7:0] DEC_H10, DEC_H1, DEC_M10, DEC_M1;
  logic [7:0] DEC_S10, DEC_S1, AP_DATA;
  logic       SEC_TICK;
  logic [1:0] SET_MODE;

  int passed = 0;
  int total  = 0;

  // model: time as seconds since midnight, mode 0/1/2
  int m_t, m_mode, m_cnt;
  bit m_tick, m_pb, m_ub;

  wt_time_keeper #(
    .TICK_DIV(TD),
    .PRESC_W (2)
  ) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .BTN_MODE(BTN_MODE),
    .BTN_UP  (BTN_UP),
    .DEC_H10 (DEC_H10),
    .DEC_H1  (DEC_H1),
    .DEC_M10 (DEC_M10),
    .DEC_M1  (DEC_M1),
    .DEC_S10 (DEC_S10),
    .DEC_S1  (DEC_S1),
    .AP_DATA (AP_DATA),
    .SEC_TICK(SEC_TICK),
    .SET_MODE(SET_MODE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [55:0] dut_disp();
    return {DEC_H10, DEC_H1, DEC_M10, DEC_M1,
            DEC_S10, DEC_S1, AP_DATA};
  endfunction

  function automatic logic [55:0] exp_disp();
    int h24, h12, mi, s;
    h24 = m_t / 3600;
    h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
    mi  = (m_t / 60) % 60;
    s   = m_t % 60;
    return {8'(48 + h12 / 10), 8'(48 + h12 % 10),
            8'(48 + mi / 10), 8'(48 + mi % 10),
            8'(48 + s / 10), 8'(48 + s % 10),
            (h24 >= 12) ? 8'h50 : 8'h41};
  endfunction

  task automatic model_step();
    bit me, ue;
    int mi;
    m_tick = 1'b0;
    if (!RESETN) begin
      m_t = 0; m_mode = 0; m_cnt = 0;
      m_pb = 1'b0; m_ub = 1'b0;
      return;
    end
    me = BTN_MODE && !m_pb;
    ue = BTN_UP && !m_ub && !me;
    m_pb = BTN_MODE;
    m_ub = BTN_UP;
    if (m_mode == 0) begin
      if (m_cnt == TD - 1) begin
        m_cnt = 0; m_tick = 1'b1;
        m_t = (m_t + 1) % 86400;
      end else m_cnt++;
    end else m_cnt = 0;
    if (m_mode == 1 && ue) m_t = (m_t + 3600) % 86400;
    if (m_mode == 2 && ue) begin
      mi  = (m_t / 60) % 60;
      m_t = m_t - mi * 60 + ((mi + 1) % 60) * 60;
    end
    if (me) begin
      if (m_mode == 2) begin
        m_t = m_t - m_t % 60;
        m_cnt = 0;
      end
      m_mode = (m_mode + 1) % 3;
    end
  endtask

  task automatic cycle(input bit bm, input bit bu);
    BTN_MODE = bm;
    BTN_UP   = bu;
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic press_mode();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  task automatic press_up();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    cycle(1'b0, 1'b0);
    RESETN = 1'b1;
  endtask

  task automatic set_hm(input int h24, input int mi);
    int n;
    press_mode();
    n = (h24 - m_t / 3600 + 24) % 24;
    for (int i = 0; i < n; i++) press_up();
    press_mode();
    n = (mi - (m_t / 60) % 60 + 60) % 60;
    for (int i = 0; i < n; i++) press_up();
    press_mode();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_disp() !== 56'h31323030303041 ||
        SET_MODE !== 2'b00 || SEC_TICK !== 1'b0)
      $display("FAIL reset: got %h mode=%b tick=%b want 31323030303041 00 0",
               dut_disp(), SET_MODE, SEC_TICK);
    else passed++;
  endtask

  task automatic test_run();
    do_reset();
    for (int i = 1; i <= TD; i++) begin
      cycle(1'b0, 1'b0);
      total++;
      if (dut_disp() !== exp_disp() || SEC_TICK !== m_tick)
        $display("FAIL run_c%0d: got %h tick=%b want %h tick=%b",
                 i, dut_disp(), SEC_TICK, exp_disp(), m_tick);
      else passed++;
    end
    total++;
    if (dut_disp() !== 56'h31323030303141 || SEC_TICK !== 1'b1)
      $display("FAIL first_tick: got %h tick=%b want 31323030303141 1",
               dut_disp(), SEC_TICK);
    else passed++;
  endtask

  task automatic test_rollover();
    do_reset();
    set_hm(11, 59);
    run(59 * TD - 1);
    total++;
    if (dut_disp() !== exp_disp())
      $display("FAIL pre_noon: got %h want %h", dut_disp(), exp_disp());
    else passed++;
    run(TD);
    total++;
    if (dut_disp() !== 56'h31323030303050 || dut_disp() !== exp_disp())
      $display("FAIL noon: got %h want 31323030303050", dut_disp());
    else passed++;
    set_hm(23, 59);
    run(60 * TD - 1);
    total++;
    if (dut_disp() !== 56'h31323030303041 || dut_disp() !== exp_disp())
      $display("FAIL midnight: got %h want 31323030303041", dut_disp());
    else passed++;
    set_hm(12, 59);
    run(60 * TD - 1);
    total++;
    if (dut_disp() !== 56'h30313030303050 || dut_disp() !== exp_disp())
      $display("FAIL one_pm: got %h want 30313030303050", dut_disp());
    else passed++;
  endtask

  task automatic test_set_hour();
    do_reset();
    press_mode();
    for (int i = 0; i < 13; i++) press_up();
    total++;
    if (SET_MODE !== 2'b01 ||
        {DEC_H10, DEC_H1, AP_DATA} !== 24'h303150 ||
        dut_disp() !== exp_disp())
      $display("FAIL set_h13: got mode=%b %h want 01 %h",
               SET_MODE, dut_disp(), exp_disp());
    else passed++;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    total++;
    if ({DEC_H10, DEC_H1, AP_DATA} !== 24'h303250)
      $display("FAIL hold_up: got %h want 303250",
               {DEC_H10, DEC_H1, AP_DATA});
    else passed++;
  endtask

  task automatic test_set_min();
    do_reset();
    press_mode();
    press_mode();
    for (int i = 0; i < 59; i++) press_up();
    total++;
    if ({DEC_M10, DEC_M1} !== 16'h3539)
      $display("FAIL min59: got %h want 3539", {DEC_M10, DEC_M1});
    else passed++;
    press_up();
    total++;
    if ({DEC_H10, DEC_H1, DEC_M10, DEC_M1} !== 32'h31323030 ||
        dut_disp() !== exp_disp())
      $display("FAIL min_wrap: got %h want 31323030",
               {DEC_H10, DEC_H1, DEC_M10, DEC_M1});
    else passed++;
    cycle(1'b1, 1'b0);
    total++;
    if (SET_MODE !== 2'b00 || {DEC_S10, DEC_S1} !== 16'h3030)
      $display("FAIL to_run: got mode=%b sec=%h want 00 3030",
               SET_MODE, {DEC_S10, DEC_S1});
    else passed++;
    for (int i = 1; i <= TD; i++) begin
      cycle(1'b0, 1'b0);
      total++;
      if (SEC_TICK !== (i == TD) || dut_disp() !== exp_disp())
        $display("FAIL tick_after_set_c%0d: got tick=%b %h want tick=%b %h",
                 i, SEC_TICK, dut_disp(), (i == TD), exp_disp());
      else passed++;
    end
  endtask

  task automatic test_together();
    do_reset();
    press_mode();
    cycle(1'b1, 1'b1);
    total++;
    if (SET_MODE !== 2'b10 ||
        {DEC_H10, DEC_H1, AP_DATA} !== 24'h313241)
      $display("FAIL mode_and_up: got mode=%b hr=%h want 10 313241",
               SET_MODE, {DEC_H10, DEC_H1, AP_DATA});
    else passed++;
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_mode();
    for (int i = 0; i < 19; i++) press_up();
    press_mode();
    for (int i = 0; i < 33; i++) press_up();
    total++;
    if (SET_MODE !== 2'b10 ||
        {DEC_H10, DEC_H1, DEC_M10, DEC_M1, AP_DATA} !== 40'h3037333350)
      $display("FAIL preset_0733p: got mode=%b %h want 10 3037333350",
               SET_MODE, {DEC_H10, DEC_H1, DEC_M10, DEC_M1, AP_DATA});
    else passed++;
    do_reset();
    total++;
    if (dut_disp() !== 56'h31323030303041 || SET_MODE !== 2'b00)
      $display("FAIL reset_mid: got %h mode=%b want 31323030303041 00",
               dut_disp(), SET_MODE);
    else passed++;
  endtask

  task automatic test_random();
    bit bm, bu;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bm = ($urandom_range(0, 9) == 0);
      bu = ($urandom_range(0, 2) == 0);
      cycle(bm, bu);
      total++;
      if (dut_disp() !== exp_disp() ||
          SET_MODE !== 2'(m_mode) || SEC_TICK !== m_tick)
        $display("FAIL random_c%0d: got %h mode=%b tick=%b want %h mode=%0d tick=%b",
                 i, dut_disp(), SET_MODE, SEC_TICK,
                 exp_disp(), m_mode, m_tick);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_rollover();
    test_set_hour();
    test_set_min();
    test_together();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
